// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter: round-robin owner arbitration of one simple_bus slave
// port among NUM_MST masters. The owner's addr/mode/wdata/start are muxed to
// the slave, s_rdy is routed back to the owner only, and s_rdata is broadcast.
// Optional BUSY watchdog: define SIMPLE_BUS_ARB_TIMEOUT_EN.
module simple_bus_arbiter #(
  parameter int unsigned NUM_MST   = 4,
  parameter int unsigned AWIDTH    = 8,
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned MAX_XFERS = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MST-1:0]          m_req,
  output logic [NUM_MST-1:0]          m_gnt,
  input  logic [NUM_MST-1:0]          m_start,
  input  logic [NUM_MST*AWIDTH-1:0]   m_addr,
  input  logic [NUM_MST*2-1:0]        m_mode,
  input  logic [NUM_MST*DWIDTH-1:0]   m_wdata,
  output logic [NUM_MST-1:0]          m_rdy,
  output logic [DWIDTH-1:0]           m_rdata,
  output logic                        s_start,
  output logic [AWIDTH-1:0]           s_addr,
  output logic [1:0]                  s_mode,
  output logic [DWIDTH-1:0]           s_wdata,
  input  logic                        s_rdy,
  input  logic [DWIDTH-1:0]           s_rdata,
  output logic                        arb_err
);

  localparam int unsigned OW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int unsigned XW = $clog2(MAX_XFERS + 1);
  localparam logic [OW-1:0] LAST_RST = OW'(NUM_MST - 1);
  localparam logic [XW-1:0] XMAX     = XW'(MAX_XFERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [OW-1:0]       owner, owner_n;
  logic [OW-1:0]       last, last_n;
  logic [OW-1:0]       winner;
  logic [XW-1:0]       xfer_cnt, xfer_n;
  logic [NUM_MST-1:0]  gnt_n;
  logic [NUM_MST-1:0]  own_oh;
  logic [NUM_MST-1:0]  others;
  logic                start_hit;
  logic                tmo_fire;

  assign own_oh    = NUM_MST'(1) << owner;
  assign others    = m_req & ~own_oh;
  assign start_hit = m_start[owner];
  assign m_rdata   = s_rdata;
  assign arb_err   = rst_n & tmo_fire;

  // Round-robin pick: first requester after the last owner, wrapping.
  always_comb begin
    logic hit;
    hit    = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NUM_MST; k++) begin
      if (!hit && m_req[OW'((32'(last) + k) % NUM_MST)]) begin
        winner = OW'((32'(last) + k) % NUM_MST);
        hit    = 1'b1;
      end
    end
  end

  // State, owner, pointer, transfer count and grant registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= LAST_RST;
      xfer_cnt <= '0;
      m_gnt    <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      last     <= last_n;
      xfer_cnt <= xfer_n;
      m_gnt    <= gnt_n;
    end
  end

  // Next-state logic; OWN decisions are taken in strict priority order.
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    xfer_n  = xfer_cnt;
    gnt_n   = m_gnt;
    case (state)
      IDLE: begin
        if (|m_req) begin
          state_n = OWN;
          owner_n = winner;
          gnt_n   = NUM_MST'(1) << winner;
          xfer_n  = '0;
        end
      end
      OWN: begin
        if (start_hit) begin
          state_n = BUSY;
          // Saturate so a long-lived owner still sees the limit once others ask.
          if (xfer_cnt != XMAX) begin
            xfer_n = xfer_cnt + XW'(1);
          end
        end else if (!m_req[owner] || ((xfer_cnt == XMAX) && (|others))) begin
          state_n = IDLE;
          gnt_n   = '0;
          last_n  = owner;
        end
      end
      BUSY: begin
        if (s_rdy || tmo_fire) begin
          state_n = OWN;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // Slave-side mux and owner-only completion; all held at 0 during reset.
  always_comb begin
    s_start = 1'b0;
    m_rdy   = '0;
    s_addr  = '0;
    s_mode  = '0;
    s_wdata = '0;
    if (rst_n) begin
      if (state == OWN) begin
        s_start = start_hit;
      end
      if ((state == BUSY) && (s_rdy || tmo_fire)) begin
        m_rdy = own_oh;
      end
      if (state != IDLE) begin
        s_addr  = m_addr[owner*AWIDTH +: AWIDTH];
        s_mode  = m_mode[owner*2 +: 2];
        s_wdata = m_wdata[owner*DWIDTH +: DWIDTH];
      end
    end
  end

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;

  // Fires on the TIMEOUT-th BUSY cycle without a slave completion.
  assign tmo_fire = (state == BUSY) && !s_rdy && (tmo_cnt == TLAST);

  // Watchdog counter: cleared on entry to BUSY, counts silent BUSY cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((state == OWN) && start_hit) begin
      tmo_cnt <= '0;
    end else if ((state == BUSY) && !s_rdy && !tmo_fire) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  // No watchdog: BUSY waits for the slave indefinitely; TIMEOUT has no effect.
  assign tmo_fire = 1'b0 && (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Directed bench for simple_bus_arbiter: a per-cycle vector table for reset,
// single transfer and round-robin order, then hand sequences for forced
// release, drop-with-start, reset mid-BUSY and the BUSY watchdog.
module tb_simple_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  m_req;
  logic [3:0]  m_gnt;
  logic [3:0]  m_start;
  logic [31:0] m_addr;
  logic [7:0]  m_mode;
  logic [31:0] m_wdata;
  logic [3:0]  m_rdy;
  logic [7:0]  m_rdata;
  logic        s_start;
  logic [7:0]  s_addr;
  logic [1:0]  s_mode;
  logic [7:0]  s_wdata;
  logic        s_rdy;
  logic [7:0]  s_rdata;
  logic        arb_err;

  int checks;
  int failures;

  logic [7:0] addr_tab [4];
  logic [1:0] mode_tab [4];
  logic [7:0] wd_tab   [4];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] start;
    logic       rdy;
    logic [3:0] egnt;
    logic       esst;
    logic [3:0] erdy;
    int         eown;
  } vec_t;

  vec_t vecs [29];

  simple_bus_arbiter #(
    .NUM_MST(4), .AWIDTH(8), .DWIDTH(8), .MAX_XFERS(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_gnt(m_gnt), .m_start(m_start),
    .m_addr(m_addr), .m_mode(m_mode), .m_wdata(m_wdata),
    .m_rdy(m_rdy), .m_rdata(m_rdata),
    .s_start(s_start), .s_addr(s_addr), .s_mode(s_mode), .s_wdata(s_wdata),
    .s_rdy(s_rdy), .s_rdata(s_rdata), .arb_err(arb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after posedge, return at the following negedge.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] start,
                     input logic rdy);
    @(posedge clk);
    #1;
    rst_n   = rst;
    m_req   = req;
    m_start = start;
    s_rdy   = rdy;
    s_rdata = s_rdata + 8'h25;
    @(negedge clk);
  endtask

  // Compare every output; eown < 0 means the slave-side mux must read 0.
  task automatic check_all(input string tag, input logic [3:0] egnt, input logic esst,
                           input logic [3:0] erdy, input int eown, input logic eerr);
    logic [7:0] ea;
    logic [1:0] em;
    logic [7:0] ew;
    ea = '0;
    em = '0;
    ew = '0;
    if (eown >= 0) begin
      ea = addr_tab[eown];
      em = mode_tab[eown];
      ew = wd_tab[eown];
    end
    chk({tag, " m_gnt"},   32'(m_gnt),   32'(egnt));
    chk({tag, " s_start"}, 32'(s_start), 32'(esst));
    chk({tag, " m_rdy"},   32'(m_rdy),   32'(erdy));
    chk({tag, " s_addr"},  32'(s_addr),  32'(ea));
    chk({tag, " s_mode"},  32'(s_mode),  32'(em));
    chk({tag, " s_wdata"}, 32'(s_wdata), 32'(ew));
    chk({tag, " arb_err"}, 32'(arb_err), 32'(eerr));
    chk({tag, " m_rdata"}, 32'(m_rdata), 32'(s_rdata));
  endtask

  task automatic setv(input int i, input logic r, input logic [3:0] rq, input logic [3:0] st,
                      input logic rd, input logic [3:0] eg, input logic es,
                      input logic [3:0] er, input int eo);
    vecs[i] = '{r, rq, st, rd, eg, es, er, eo};
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    addr_tab = '{8'h5A, 8'hB1, 8'hC2, 8'hD3};
    mode_tab = '{2'b00, 2'b01, 2'b00, 2'b01};
    wd_tab   = '{8'h11, 8'h22, 8'h33, 8'h44};
    m_addr   = 32'hD3C2B15A;
    m_mode   = 8'b01_00_01_00;
    m_wdata  = 32'h44332211;
    rst_n    = 1'b0;
    m_req    = '0;
    m_start  = '0;
    s_rdy    = 1'b0;
    s_rdata  = 8'h00;

    //      idx rst req      start    rdy   egnt     esst  erdy     eown
    setv( 0, 1, 4'b0001, 4'b0000, 0, 4'b0000, 0, 4'b0000, -1);
    setv( 1, 1, 4'b0001, 4'b0001, 0, 4'b0001, 1, 4'b0000,  0);
    setv( 2, 1, 4'b0001, 4'b0000, 0, 4'b0001, 0, 4'b0000,  0);
    setv( 3, 1, 4'b0001, 4'b0000, 1, 4'b0001, 0, 4'b0001,  0);
    setv( 4, 1, 4'b0000, 4'b0000, 0, 4'b0001, 0, 4'b0000,  0);
    setv( 5, 1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, -1);
    setv( 6, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, -1);
    setv( 7, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'b0000, -1);
    setv( 8, 1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'b0000, -1);
    setv( 9, 1, 4'b1111, 4'b0001, 0, 4'b0001, 1, 4'b0000,  0);
    setv(10, 1, 4'b1111, 4'b0000, 1, 4'b0001, 0, 4'b0001,  0);
    setv(11, 1, 4'b1110, 4'b0000, 0, 4'b0001, 0, 4'b0000,  0);
    setv(12, 1, 4'b1110, 4'b0000, 0, 4'b0000, 0, 4'b0000, -1);
    setv(13, 1, 4'b1110, 4'b0010, 0, 4'b0010, 1, 4'b0000,  1);
    setv(14, 1, 4'b1110, 4'b0000, 1, 4'b0010, 0, 4'b0010,  1);
    setv(15, 1, 4'b1100, 4'b0000, 0, 4'b0010, 0, 4'b0000,  1);
    setv(16, 1, 4'b1100, 4'b0000, 0, 4'b0000, 0, 4'b0000, -1);
    setv(17, 1, 4'b1100, 4'b0100, 0, 4'b0100, 1, 4'b0000,  2);
    setv(18, 1, 4'b1100, 4'b0000, 1, 4'b0100, 0, 4'b0100,  2);
    setv(19, 1, 4'b1000, 4'b0000, 0, 4'b0100, 0, 4'b0000,  2);
    setv(20, 1, 4'b1000, 4'b0000, 0, 4'b0000, 0, 4'b0000, -1);
    setv(21, 1, 4'b1000, 4'b1000, 0, 4'b1000, 1, 4'b0000,  3);
    setv(22, 1, 4'b1000, 4'b0000, 1, 4'b1000, 0, 4'b1000,  3);
    setv(23, 1, 4'b0000, 4'b0000, 0, 4'b1000, 0, 4'b0000,  3);
    setv(24, 1, 4'b1001, 4'b0000, 0, 4'b0000, 0, 4'b0000, -1);
    setv(25, 1, 4'b1000, 4'b1000, 0, 4'b0001, 0, 4'b0000,  0);
    setv(26, 1, 4'b1000, 4'b1000, 0, 4'b0000, 0, 4'b0000, -1);
    setv(27, 1, 4'b0000, 4'b0000, 0, 4'b1000, 0, 4'b0000,  3);
    setv(28, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, -1);

    // Held in reset: everything but m_rdata reads 0.
    cyc(0, 4'b0000, 4'b0000, 0);
    cyc(0, 4'b0001, 4'b0001, 1);
    check_all("reset", 4'b0000, 0, 4'b0000, -1, 0);

    // Single transfer, round-robin order and pointer wrap.
    for (int i = 0; i < 29; i++) begin
      cyc(vecs[i].rst, vecs[i].req, vecs[i].start, vecs[i].rdy);
      check_all($sformatf("v%0d", i), vecs[i].egnt, vecs[i].esst, vecs[i].erdy,
                vecs[i].eown, 0);
    end

    // Forced release after MAX_XFERS while master 2 waits.
    cyc(1, 4'b0110, 4'b0000, 0); check_all("c idle", 4'b0000, 0, 4'b0000, -1, 0);
    for (int r = 0; r < 4; r++) begin
      cyc(1, 4'b0110, 4'b0010, 0);
      check_all($sformatf("c start%0d", r), 4'b0010, 1, 4'b0000, 1, 0);
      cyc(1, 4'b0110, 4'b0000, 1);
      check_all($sformatf("c rdy%0d", r), 4'b0010, 0, 4'b0010, 1, 0);
    end
    cyc(1, 4'b0110, 4'b0000, 0); check_all("c limit own", 4'b0010, 0, 4'b0000, 1, 0);
    cyc(1, 4'b0110, 4'b0000, 0); check_all("c forced idle", 4'b0000, 0, 4'b0000, -1, 0);
    cyc(1, 4'b0010, 4'b0000, 0); check_all("c gnt2", 4'b0100, 0, 4'b0000, 2, 0);
    cyc(1, 4'b0010, 4'b0000, 0); check_all("c idle2", 4'b0000, 0, 4'b0000, -1, 0);

    // No other requester: master 1 keeps the grant past the limit.
    for (int r = 0; r < 5; r++) begin
      cyc(1, 4'b0010, 4'b0010, 0);
      check_all($sformatf("c solo start%0d", r), 4'b0010, 1, 4'b0000, 1, 0);
      cyc(1, 4'b0010, 4'b0000, 1);
      check_all($sformatf("c solo rdy%0d", r), 4'b0010, 0, 4'b0010, 1, 0);
    end
    cyc(1, 4'b0010, 4'b0000, 0); check_all("c keep", 4'b0010, 0, 4'b0000, 1, 0);
    cyc(1, 4'b0110, 4'b0000, 0); check_all("c keep2", 4'b0010, 0, 4'b0000, 1, 0);
    cyc(1, 4'b0100, 4'b0000, 0); check_all("c late release", 4'b0000, 0, 4'b0000, -1, 0);
    cyc(1, 4'b0000, 4'b0000, 0); check_all("c gnt2b", 4'b0100, 0, 4'b0000, 2, 0);

    // Owner drops m_req in its start cycle; non-owner start is ignored.
    cyc(1, 4'b1000, 4'b0000, 0); check_all("d idle", 4'b0000, 0, 4'b0000, -1, 0);
    cyc(1, 4'b0000, 4'b1000, 0); check_all("d start drop", 4'b1000, 1, 4'b0000, 3, 0);
    cyc(1, 4'b0000, 4'b0000, 0); check_all("d busy", 4'b1000, 0, 4'b0000, 3, 0);
    cyc(1, 4'b0000, 4'b0000, 1); check_all("d rdy", 4'b1000, 0, 4'b1000, 3, 0);
    cyc(1, 4'b0000, 4'b0000, 0); check_all("d own", 4'b1000, 0, 4'b0000, 3, 0);
    cyc(1, 4'b0001, 4'b0000, 0); check_all("d idle2", 4'b0000, 0, 4'b0000, -1, 0);
    cyc(1, 4'b0001, 4'b1000, 0); check_all("d nonowner", 4'b0001, 0, 4'b0000, 0, 0);
    cyc(1, 4'b0001, 4'b0001, 0); check_all("d start0", 4'b0001, 1, 4'b0000, 0, 0);
    cyc(1, 4'b0001, 4'b0000, 0); check_all("d busy0", 4'b0001, 0, 4'b0000, 0, 0);

    // Reset while BUSY: transfer abandoned, first grant afterwards to master 0.
    cyc(0, 4'b0001, 4'b0000, 1);
    chk("e in-reset m_rdy", 32'(m_rdy), 32'(4'b0000));
    chk("e in-reset s_start", 32'(s_start), 32'(1'b0));
    chk("e in-reset s_addr", 32'(s_addr), 32'(8'h00));
    cyc(1, 4'b1111, 4'b0001, 1); check_all("e after", 4'b0000, 0, 4'b0000, -1, 0);
    cyc(1, 4'b0000, 4'b0000, 0); check_all("e first gnt", 4'b0001, 0, 4'b0000, 0, 0);

    // BUSY with a silent slave.
    cyc(1, 4'b0001, 4'b0000, 0); check_all("f idle", 4'b0000, 0, 4'b0000, -1, 0);
    cyc(1, 4'b0001, 4'b0001, 0); check_all("f start", 4'b0001, 1, 4'b0000, 0, 0);
    for (int k = 1; k < 8; k++) begin
      cyc(1, 4'b0001, 4'b0000, 0);
      check_all($sformatf("f wait%0d", k), 4'b0001, 0, 4'b0000, 0, 0);
    end
    cyc(1, 4'b0001, 4'b0000, 0);
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    check_all("f timeout", 4'b0001, 0, 4'b0001, 0, 1);
    cyc(1, 4'b0001, 4'b0000, 1); check_all("f stray rdy", 4'b0001, 0, 4'b0000, 0, 0);
    cyc(1, 4'b0000, 4'b0000, 0); check_all("f own", 4'b0001, 0, 4'b0000, 0, 0);
`else
    check_all("f no timeout", 4'b0001, 0, 4'b0000, 0, 0);
    for (int k = 9; k < 21; k++) begin
      cyc(1, 4'b0001, 4'b0000, 0);
      check_all($sformatf("f wait%0d", k), 4'b0001, 0, 4'b0000, 0, 0);
    end
    cyc(1, 4'b0001, 4'b0000, 1); check_all("f late rdy", 4'b0001, 0, 4'b0001, 0, 0);
    cyc(1, 4'b0000, 4'b0000, 0); check_all("f own", 4'b0001, 0, 4'b0000, 0, 0);
`endif
    cyc(1, 4'b0000, 4'b0000, 0); check_all("f idle end", 4'b0000, 0, 4'b0000, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_bus_arbiter.md
Name: simple_bus_arbiter

Overview:
- Shares one simple_bus slave port (e.g. a memory) between NUM_MST masters (CPU-style requesters).
- Round-robin grant.
- Muxes the owner's addr/mode/start/wdata to the slave; routes rdy back to the owner only; broadcasts rdata.
- Sits between the master-side modports and the single slave-side modport.

Parameters:
- NUM_MST, 4, number of requesting masters (2..8)
- AWIDTH, 8, address width
- DWIDTH, 8, data width
- MAX_XFERS, 4, completed transfers an owner may perform before forced release when others wait (1..255)
- TIMEOUT, 64, cycles in BUSY before watchdog fires (only with SIMPLE_BUS_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- m_req  in  NUM_MST  per-master bus request
- m_gnt  out  NUM_MST  one-hot grant, registered
- m_start  in  NUM_MST  per-master transfer start pulse
- m_addr  in  NUM_MST*AWIDTH  packed addresses, master i at [i*AWIDTH +: AWIDTH]
- m_mode  in  NUM_MST*2  packed mode, bit0: 0=read, 1=write
- m_wdata  in  NUM_MST*DWIDTH  packed write data
- m_rdy  out  NUM_MST  transfer-complete, owner only
- m_rdata  out  DWIDTH  read data, broadcast (= s_rdata)
- s_start  out  1  start pulse to slave
- s_addr  out  AWIDTH  muxed address
- s_mode  out  2  muxed mode
- s_wdata  out  DWIDTH  muxed write data
- s_rdy  in  1  slave transfer complete
- s_rdata  in  DWIDTH  slave read data
- arb_err  out  1  watchdog timeout pulse

Interface (already decided):
- One clock, clk.
- Reset rst_n is synchronous and active-low.

Behaviour:
- State registers: state {IDLE, OWN, BUSY}, owner index, rr pointer last, xfer_cnt.
- Reset: state=IDLE, m_gnt=0, last=NUM_MST-1 (master 0 has first priority), xfer_cnt=0, arb_err=0.
  - While held in reset, all outputs are 0 except m_rdata.
- IDLE:
  - If any m_req, the winner is the first set bit scanning from last+1 upward, with wrap.
  - Next cycle: owner=winner, m_gnt[winner]=1, state=OWN, xfer_cnt=0. Request-to-grant latency is 1 cycle.
- OWN, evaluated in priority order:
  1. m_start[owner]=1 → state=BUSY; s_start=1 this cycle only (combinational from the registered state); xfer_cnt+1.
  2. else m_req[owner]=0 → state=IDLE, m_gnt=0, last=owner.
  3. else xfer_cnt==MAX_XFERS and any other m_req set → forced release: IDLE, m_gnt=0, last=owner.
  4. else stay in OWN.
- BUSY:
  - Wait for s_rdy. s_rdy is ignored outside BUSY.
  - On s_rdy: m_rdy[owner]=1 for that cycle (combinational), state=OWN.
  - Minimum transfer is 2 cycles: the start cycle plus an rdy cycle.
  - m_req changes during BUSY are ignored; the grant is held until the transfer completes.
- Muxes: s_addr/s_mode/s_wdata select on the registered owner whenever state!=IDLE, and are 0 in IDLE.
- m_start from a non-owner, or in IDLE/BUSY, is ignored; no s_start is produced.
- There is always exactly one dead IDLE cycle between owners. The gnt-to-gnt gap for a new owner is ≥2 cycles.
- Pointer wrap: last=NUM_MST-1 → scanning starts at 0.
- No requests → stay in IDLE; the pointer is unchanged.
- Reset mid-BUSY: the transfer is abandoned, no m_rdy is issued, and the slave sees s_start=0 from the next cycle.

Optional Feature:
- Macro SIMPLE_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to BUSY and counts each BUSY cycle without s_rdy.
  - On reaching TIMEOUT: arb_err=1 for one cycle, m_rdy[owner]=1 (synthesized completion), state=OWN. This cycle does not count as a slave completion.
  - A late s_rdy arriving after that point is ignored unless state=BUSY.
- Undefined: arb_err is tied 0, no counter logic exists, and BUSY waits indefinitely.

Test Plan:
- Reset then m_req=0001 → m_gnt=0001 one cycle later. m_start[0] with addr 0x5A → s_start one pulse, s_addr=0x5A. s_rdy two cycles later → m_rdy=0001 in the same cycle.
- m_req=1111 held, each owner does 1 transfer then drops req → grant order 0,1,2,3, one IDLE cycle between each; then m_req=1001 → grant 0, then 3.
- MAX_XFERS=4, master 1 holds req with back-to-back transfers while m_req[2]=1 → after the 4th s_rdy, m_gnt[1] drops and m_gnt[2] rises 2 cycles later; with master 2 idle, master 1 keeps the grant past 4 transfers.
- Owner drops m_req in the same cycle as m_start → transfer proceeds (BUSY), m_rdy is delivered, then release on the next OWN cycle; m_start[3] from a non-owner → s_start stays 0.
- rst_n=0 asserted while in BUSY → the next cycle has m_gnt=0, s_start=0, and no m_rdy; the first grant after release of reset goes to master 0.
- With SIMPLE_BUS_ARB_TIMEOUT_EN and TIMEOUT=8, s_rdy never asserted → arb_err and m_rdy[owner] pulse exactly 8 cycles after s_start; a later stray s_rdy in OWN produces no m_rdy.
